// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every non-clock/reset signal of the fetch stage.
//   Member names follow the fetch unit's own port directions.
//
//   Redirect from jump/branch unit:
//     redirect_i, redirect_pc_i
//   Instruction memory bus (single outstanding request):
//     imem_addr_o, imem_valid_o   (fetch -> memory)
//     imem_ack_i, imem_data_i     (memory -> fetch)
//   Decode handshake:
//     instr_o, pc_o, valid_o      (fetch -> decode)
//     ready_i                     (decode -> fetch)
//
//   master : the fetch unit
//   slave  : its environment (memory, decode, branch unit)
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic        imem_valid_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    input  redirect_i, redirect_pc_i, imem_ack_i, imem_data_i, ready_i,
    output imem_addr_o, imem_valid_o, instr_o, pc_o, valid_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_ack_i, imem_data_i, ready_i,
    input  imem_addr_o, imem_valid_o, instr_o, pc_o, valid_o
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC, issues one outstanding word
//   request at a time to instruction memory, buffers returned words in a
//   2-entry FIFO and presents {pc, instr} to decode. A redirect flushes the
//   FIFO and refetches from the (word-aligned) target; a response that was
//   already in flight when the redirect arrived is discarded.
//
//   Ports:
//     clk_i  : core clock, all state updates on the rising edge
//     rst_i  : synchronous reset, active-high
//     bus    : fetch_unit_if.master (redirect, imem bus, decode handshake)
//   Parameter:
//     RESET_PC_ADDR : fetch PC after reset (bits [1:0] must be 0)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC_ADDR = 32'h0001_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request on the bus
    REQ   = 2'd1,  // live request, data will be buffered
    FLUSH = 2'd2   // stale request after a redirect, data will be dropped
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        imem_valid;
  logic        fifo_valid;
  logic        flush;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  assign redirect_target = bus.redirect_pc_i & ~32'h3;
  assign imem_valid      = (state_q != IDLE);
  assign fifo_valid      = (count_q != 2'd0);

  // A redirect wins over everything else this cycle: the FIFO empties, the
  // decode pop is ignored and any word acked right now is thrown away.
  assign flush = bus.redirect_i;
  assign push  = (state_q == REQ) && bus.imem_ack_i && !flush;
  assign pop   = fifo_valid && bus.ready_i && !flush;

  always_comb begin
    if (flush) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d    = REQ;
          fetch_pc_d = redirect_target;
        end else if (count_d < 2'd2) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (flush) begin
          if (bus.imem_ack_i) begin
            // Bus is free now: restart straight at the target.
            state_d    = REQ;
            fetch_pc_d = redirect_target;
          end else begin
            // Keep the bus address stable until the old request completes.
            state_d      = FLUSH;
            pending_pc_d = redirect_target;
          end
        end else if (bus.imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_d < 2'd2) ? REQ : IDLE;
        end
      end

      FLUSH: begin
        if (flush) begin
          pending_pc_d = redirect_target;
        end
        if (bus.imem_ack_i) begin
          // The newest target counts, even if it arrives with the ack.
          state_d    = REQ;
          fetch_pc_d = flush ? redirect_target : pending_pc_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC_ADDR;
      pending_pc_q <= RESET_PC_ADDR;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q ^ push;
        rd_ptr_q <= rd_ptr_q ^ pop;
      end
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only ever read after it
  // has been written, and the empty outputs are forced to zero below.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_data_i;
    end
  end

  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.imem_valid_o = imem_valid;
  assign bus.valid_o      = fifo_valid;
  assign bus.pc_o         = fifo_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  assign bus.instr_o      = fifo_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;

endmodule
